windowed_channel_averager: RTL

//  Multi-channel moving-window averager for time-multiplexed sample streams (ADC/control path).

---
 rtl/windowed_channel_averager.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/windowed_channel_averager.sv
// windowed_channel_averager
//   Multi-channel moving-window averager for a time-multiplexed sample
//   stream. Each channel owns a circular window of the last WINDOW samples
//   and a running sum. Every accepted sample produces one result, either
//   the window average (sum >>> LOG2_WINDOW) or the raw sum.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-low reset
//   clear        synchronous flush of all windows, sums and counters
//   in_data      signed input sample
//   in_channel   channel index of in_data
//   in_valid     sample present
//   in_ready     block can accept a sample
//   out_data     signed windowed result
//   out_channel  channel of out_data
//   out_valid    result present
//   out_ready    downstream accepts the result
//   out_full     result channel has seen >= WINDOW samples since last flush
module windowed_channel_averager #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int N_CHANNELS  = 4,
  parameter  int WINDOW      = 8,
  parameter  int SUM_MODE    = 0,
  localparam int CH_WIDTH    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int LOG2_WINDOW = $clog2(WINDOW),
  localparam int ACC_WIDTH   = DATA_WIDTH + LOG2_WINDOW,
  localparam int OUT_WIDTH   = (SUM_MODE != 0) ? ACC_WIDTH : DATA_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic        [CH_WIDTH-1:0]   in_channel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic        [CH_WIDTH-1:0]   out_channel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_full
);

  localparam int CNT_WIDTH = $clog2(WINDOW + 1);

  if ((WINDOW < 2) || ((WINDOW & (WINDOW - 1)) != 0)) begin : g_bad_window
    $error("windowed_channel_averager: WINDOW must be a power of two >= 2");
  end

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                        r_state;
  logic [LOG2_WINDOW-1:0]        r_idx;
  logic signed [DATA_WIDTH-1:0]  r_buf [N_CHANNELS][WINDOW];
  logic signed [ACC_WIDTH-1:0]   r_sum [N_CHANNELS];
  logic [LOG2_WINDOW-1:0]        r_ptr [N_CHANNELS];
  logic [CNT_WIDTH-1:0]          r_cnt [N_CHANNELS];

  logic signed [OUT_WIDTH-1:0]   r_out_data;
  logic [CH_WIDTH-1:0]           r_out_channel;
  logic                          r_out_valid;
  logic                          r_out_full;

  logic                          w_ch_ok;
  logic                          w_accept;
  logic                          w_take;
  logic signed [DATA_WIDTH-1:0]  w_old;
  logic signed [ACC_WIDTH-1:0]   w_new_sum;
  logic signed [ACC_WIDTH-1:0]   w_result;
  logic [CNT_WIDTH-1:0]          w_cnt_next;

  // Channel indices beyond N_CHANNELS can only occur when N_CHANNELS is
  // not a power of two; such samples are consumed and ignored.
  if (N_CHANNELS == (1 << CH_WIDTH)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign w_ch_ok = (in_channel < CH_WIDTH'(N_CHANNELS));
  end

  // One-deep output register: a new sample may enter whenever the held
  // result is absent or leaving this cycle.
  assign in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready && !clear;
  assign w_take   = w_accept && w_ch_ok;

  always_comb begin
    w_old      = '0;
    w_new_sum  = '0;
    w_cnt_next = '0;
    if (w_ch_ok) begin
      w_old      = r_buf[in_channel][r_ptr[in_channel]];
      w_new_sum  = r_sum[in_channel] + ACC_WIDTH'(in_data) - ACC_WIDTH'(w_old);
      w_cnt_next = (r_cnt[in_channel] == CNT_WIDTH'(WINDOW)) ? r_cnt[in_channel]
                                                              : r_cnt[in_channel] + 1'b1;
    end
    w_result = (SUM_MODE != 0) ? w_new_sum : (w_new_sum >>> LOG2_WINDOW);
  end

  // Window storage has no reset; the INIT sweep zeroes it after every
  // reset release or clear before any sample is accepted.
  always_ff @(posedge clock) begin
    if (r_state == S_INIT) begin
      for (int unsigned c = 0; c < N_CHANNELS; c++) begin
        r_buf[c][r_idx] <= '0;
      end
    end else if (w_take) begin
      r_buf[in_channel][r_ptr[in_channel]] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_INIT;
      r_idx         <= '0;
      r_out_data    <= '0;
      r_out_channel <= '0;
      r_out_valid   <= 1'b0;
      r_out_full    <= 1'b0;
      for (int unsigned c = 0; c < N_CHANNELS; c++) begin
        r_sum[c] <= '0;
        r_ptr[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else if (clear) begin
      r_state     <= S_INIT;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          for (int unsigned c = 0; c < N_CHANNELS; c++) begin
            r_sum[c] <= '0;
            r_ptr[c] <= '0;
            r_cnt[c] <= '0;
          end
          r_idx <= r_idx + 1'b1;
          if (r_idx == LOG2_WINDOW'(WINDOW - 1)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_take) begin
            r_sum[in_channel] <= w_new_sum;
            // WINDOW is a power of two, so the pointer wraps naturally.
            r_ptr[in_channel] <= r_ptr[in_channel] + 1'b1;
            r_cnt[in_channel] <= w_cnt_next;
            r_out_data        <= w_result[OUT_WIDTH-1:0];
            r_out_channel     <= in_channel;
            r_out_full        <= (w_cnt_next == CNT_WIDTH'(WINDOW));
            r_out_valid       <= 1'b1;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign out_data    = r_out_data;
  assign out_channel = r_out_channel;
  assign out_valid   = r_out_valid;
  assign out_full    = r_out_full;

endmodule
